btb_predictor: RTL and testbench

Parametrised direct-mapped branch target buffer with per-entry tag, valid bit, target and 2-bit saturating direction counter. Sits between the PC register and IF/ID: looks up the current fetch PC combinationally and supplies the next fetch address plus a taken flag; trained from EX with resolved branch outcomes. Adds tag compare, hysteresis, unconditional-jump handling, a sequential post-reset invalidation sweep and a mispredict statistic.

---
 rtl/btb_pkg.sv | 25 ++
 rtl/bp_sat_ctr.sv | 31 +++
 rtl/btb_predictor.sv | 167 ++++++++++++++++
 tb/tb_btb_predictor.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// btb_pkg: shared types and helpers for the branch target buffer.
//   btb_state_e : table state (INIT sweep, RUN)
//   CTR_*       : 2-bit direction counter encodings
//   alloc_ctr() : starting counter value for a newly allocated entry
package btb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } btb_state_e;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  // A fresh entry starts one step off the saturated end of its observed
  // direction, so a single contrary outcome flips it; jumps start saturated.
  function automatic logic [1:0] alloc_ctr(input logic uncond, input logic taken);
    if (uncond)     return CTR_ST;
    else if (taken) return CTR_WT;
    else            return CTR_WNT;
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// bp_sat_ctr: combinational next-value function for a 2-bit saturating
// direction counter.
//   ctr      in  current counter (ignored on a miss)
//   taken    in  resolved direction
//   uncond   in  resolved instruction is an unconditional jump
//   hit      in  entry matched; on a miss the allocation value is produced
//   ctr_next out next counter value
module bp_sat_ctr
  import btb_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  input  logic       uncond,
  input  logic       hit,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (!hit) begin
      ctr_next = alloc_ctr(uncond, taken);
    end else if (uncond) begin
      ctr_next = CTR_ST;
    end else if (taken) begin
      ctr_next = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end else begin
      ctr_next = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped branch target buffer with 2-bit direction
// counters, combinational lookup and EX-side training.
//   clk, rst        clock; synchronous active-high reset
//   pc              current fetch PC
//   pred_pc         predicted next fetch address
//   pred_taken      predicted-taken flag
//   ready           table swept clean, predictions valid
//   upd_valid       EX resolved a branch/jump this cycle
//   upd_pc          PC of the resolved instruction
//   upd_taken       actual direction
//   upd_target      actual target when taken
//   upd_uncond      resolved instruction is an unconditional jump
//   upd_mispredict  EX detected a misprediction
//   mispred_cnt     saturating mispredict count
module btb_predictor
  import btb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 8,
  parameter int CTR_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pred_pc,
  output logic              pred_taken,
  output logic              ready,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_uncond,
  input  logic              upd_mispredict,
  output logic [31:0]       mispred_cnt
);

  localparam int DEPTH = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  // Entry storage. Only valid is ever cleared (by the INIT sweep); the other
  // fields are meaningless until valid is set and so carry no reset.
  logic [DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q    [DEPTH];
  logic [ADDR_W-1:0] target_q [DEPTH];
  logic [CTR_W-1:0]  ctr_q    [DEPTH];

  btb_state_e        state_q, state_d;
  logic [INDEX_W-1:0] sweep_idx_q, sweep_idx_d;
  logic [31:0]       mispred_cnt_q, mispred_cnt_d;

  // Lookup side
  logic [INDEX_W-1:0] l_idx;
  logic [TAG_W-1:0]   l_tag;
  logic               l_hit;

  // Update side
  logic [INDEX_W-1:0] u_idx;
  logic [TAG_W-1:0]   u_tag;
  logic               u_hit;
  logic [1:0]         u_ctr_next;
  logic               run;
  logic               upd_en;
  logic               tgt_we;
  logic               clr_en;
  logic [1:0]         unused_upd_lsb;

  assign unused_upd_lsb = upd_pc[1:0];

  // ---------------------------------------------------------------------
  // Lookup: purely combinational on pc, reads pre-update contents.
  // ---------------------------------------------------------------------
  always_comb begin
    l_idx      = pc[INDEX_W+1:2];
    l_tag      = pc[ADDR_W-1:INDEX_W+2];
    l_hit      = ready & valid_q[l_idx] & (tag_q[l_idx] == l_tag);
    pred_taken = l_hit & ctr_q[l_idx][1];
    pred_pc    = pred_taken ? target_q[l_idx] : pc + ADDR_W'(4);
  end

  // ---------------------------------------------------------------------
  // Update decode
  // ---------------------------------------------------------------------
  always_comb begin
    u_idx  = upd_pc[INDEX_W+1:2];
    u_tag  = upd_pc[ADDR_W-1:INDEX_W+2];
    u_hit  = valid_q[u_idx] & (tag_q[u_idx] == u_tag);
    // An update arriving together with rst is dropped.
    upd_en = run & upd_valid & ~rst;
    // Target is kept only on a not-taken conditional hit.
    tgt_we = upd_en & (~u_hit | upd_taken | upd_uncond);
  end

  bp_sat_ctr u_sat_ctr (
    .ctr      (ctr_q[u_idx]),
    .taken    (upd_taken),
    .uncond   (upd_uncond),
    .hit      (u_hit),
    .ctr_next (u_ctr_next)
  );

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= INIT;
      sweep_idx_q   <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      sweep_idx_q   <= sweep_idx_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state / counters
  // ---------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    sweep_idx_d   = sweep_idx_q;
    mispred_cnt_d = mispred_cnt_q;
    case (state_q)
      INIT: begin
        if (sweep_idx_q == INDEX_W'(DEPTH - 1)) begin
          sweep_idx_d = '0;
          state_d     = RUN;
        end else begin
          sweep_idx_d = sweep_idx_q + 1'b1;
        end
      end
      RUN: begin
        if (upd_valid && upd_mispredict && !(&mispred_cnt_q)) begin
          mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    run         = (state_q == RUN);
    ready       = run;
    clr_en      = (state_q == INIT) & ~rst;
    mispred_cnt = mispred_cnt_q;
  end

  // ---------------------------------------------------------------------
  // Table write port: sweep clear in INIT, training in RUN.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr_en) begin
      valid_q[sweep_idx_q] <= 1'b0;
    end else if (upd_en) begin
      valid_q[u_idx] <= 1'b1;
      tag_q[u_idx]   <= u_tag;
      ctr_q[u_idx]   <= u_ctr_next;
    end
    if (tgt_we) begin
      target_q[u_idx] <= upd_target;
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
module tb_btb_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        ready;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_uncond;
  logic        upd_mispredict;
  logic [31:0] mispred_cnt;

  int n_checks;
  int n_fail;

  btb_predictor #(.ADDR_W(32), .INDEX_W(8), .CTR_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .ready          (ready),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_uncond     (upd_uncond),
    .upd_mispredict (upd_mispredict),
    .mispred_cnt    (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [31:0] a, input logic tk, input logic [31:0] tgt,
                           input logic unc, input logic mp);
    upd_valid      = 1'b1;
    upd_pc         = a;
    upd_taken      = tk;
    upd_target     = tgt;
    upd_uncond     = unc;
    upd_mispredict = mp;
    tick();
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic look(input string name, input logic [31:0] a,
                      input logic exp_tk, input logic [31:0] exp_pc);
    pc = a;
    #1;
    n_checks++;
    if (pred_taken !== exp_tk) begin
      n_fail++;
      $display("FAIL %s pred_taken: got %0b expected %0b", name, pred_taken, exp_tk);
    end
    n_checks++;
    if (pred_pc !== exp_pc) begin
      n_fail++;
      $display("FAIL %s pred_pc: got %h expected %h", name, pred_pc, exp_pc);
    end
  endtask

  // Releases rst and counts posedges until ready; expects exactly 256.
  task automatic sweep_and_check(input string name);
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i < 256) begin
        n_checks++;
        if (ready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s ready early at cycle %0d: got %0b expected 0", name, i, ready);
        end
        if (i == 17 || i == 200) begin
          pc = 32'h0000_1234 + 32'(i * 16);
          #1;
          n_checks++;
          if (pred_pc !== pc + 32'd4 || pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL %s init pred: got %h/%0b expected %h/0", name, pred_pc, pred_taken, pc + 32'd4);
          end
        end
      end else begin
        n_checks++;
        if (ready !== 1'b1) begin
          n_fail++;
          $display("FAIL %s ready at cycle 256: got %0b expected 1", name, ready);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    pc = 32'h0000_0010;
    #1;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset ready: got %0b expected 0", ready);
    end
    n_checks++;
    if (pred_pc !== 32'h0000_0014 || pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL reset pred: got %h/%0b expected 00000014/0", pred_pc, pred_taken);
    end
    n_checks++;
    if (mispred_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset mispred_cnt: got %0d expected 0", mispred_cnt);
    end
    rst = 1'b0;
    sweep_and_check("reset_sweep");
    look("empty_table", 32'h0000_0100, 1'b0, 32'h0000_0104);
  endtask

  task automatic test_alloc_taken();
    do_update(32'h0000_0100, 1'b1, 32'h0000_0200, 1'b0, 1'b0);
    look("alloc_hit", 32'h0000_0100, 1'b1, 32'h0000_0200);
    look("alloc_tag_miss", 32'h0000_0500, 1'b0, 32'h0000_0504);
  endtask

  task automatic test_hysteresis();
    for (int i = 0; i < 3; i++) do_update(32'h0000_0100, 1'b1, 32'h0000_0200, 1'b0, 1'b0);
    do_update(32'h0000_0100, 1'b0, 32'h0000_0200, 1'b0, 1'b0);
    look("hyst_one_nt", 32'h0000_0100, 1'b1, 32'h0000_0200);
    do_update(32'h0000_0100, 1'b0, 32'h0000_0200, 1'b0, 1'b0);
    look("hyst_two_nt", 32'h0000_0100, 1'b0, 32'h0000_0104);
  endtask

  task automatic test_uncond();
    do_update(32'h0000_0040, 1'b0, 32'h0000_0999, 1'b0, 1'b0);
    look("alloc_nt", 32'h0000_0040, 1'b0, 32'h0000_0044);
    do_update(32'h0000_0040, 1'b1, 32'h0000_0300, 1'b1, 1'b0);
    look("uncond_taken", 32'h0000_0040, 1'b1, 32'h0000_0300);
    // ctr 3 -> 2, target must survive a not-taken update
    do_update(32'h0000_0040, 1'b0, 32'h0000_0777, 1'b0, 1'b0);
    look("nt_keeps_target", 32'h0000_0040, 1'b1, 32'h0000_0300);
  endtask

  task automatic test_same_cycle();
    look("pre_same_cycle", 32'h0000_0080, 1'b0, 32'h0000_0084);
    upd_valid  = 1'b1;
    upd_pc     = 32'h0000_0080;
    upd_taken  = 1'b1;
    upd_target = 32'h0000_0400;
    upd_uncond = 1'b0;
    look("same_cycle_old", 32'h0000_0080, 1'b0, 32'h0000_0084);
    tick();
    upd_valid = 1'b0;
    look("same_cycle_new", 32'h0000_0080, 1'b1, 32'h0000_0400);
    // ctr 2 -> 1 -> 0 -> 0, then taken -> 1: still not taken if no wrap
    for (int i = 0; i < 3; i++) do_update(32'h0000_0080, 1'b0, 32'h0000_0400, 1'b0, 1'b0);
    look("sat_low", 32'h0000_0080, 1'b0, 32'h0000_0084);
    do_update(32'h0000_0080, 1'b1, 32'h0000_0400, 1'b0, 1'b0);
    look("sat_low_then_t", 32'h0000_0080, 1'b0, 32'h0000_0084);
    do_update(32'h0000_0080, 1'b1, 32'h0000_0400, 1'b0, 1'b0);
    look("sat_low_then_tt", 32'h0000_0080, 1'b1, 32'h0000_0400);
  endtask

  task automatic test_mispredict();
    for (int i = 0; i < 5; i++) do_update(32'h0000_0900 + 32'(i * 4), 1'b1, 32'h0000_0a00, 1'b0, 1'b1);
    // mispredict without upd_valid must not count
    upd_mispredict = 1'b1;
    tick();
    upd_mispredict = 1'b0;
    n_checks++;
    if (mispred_cnt !== 32'd5) begin
      n_fail++;
      $display("FAIL mispred_cnt: got %0d expected 5", mispred_cnt);
    end
  endtask

  task automatic test_reset_mid_sweep();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    // update during INIT is ignored
    do_update(32'h0000_0100, 1'b1, 32'h0000_0200, 1'b0, 1'b1);
    for (int i = 0; i < 48; i++) tick();
    n_checks++;
    if (ready !== 1'b0 || mispred_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_sweep state: got ready=%0b cnt=%0d expected 0/0", ready, mispred_cnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sweep_and_check("restart_sweep");
    n_checks++;
    if (mispred_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL restart mispred_cnt: got %0d expected 0", mispred_cnt);
    end
    look("swept_entry", 32'h0000_0100, 1'b0, 32'h0000_0104);
    // reset while running: update in the rst cycle must be dropped
    upd_valid = 1'b1; upd_pc = 32'h0000_0100; upd_taken = 1'b1;
    upd_target = 32'h0000_0200; upd_uncond = 1'b1; upd_mispredict = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    sweep_and_check("run_reset_sweep");
    look("dropped_update", 32'h0000_0100, 1'b0, 32'h0000_0104);
    n_checks++;
    if (mispred_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL dropped mispred_cnt: got %0d expected 0", mispred_cnt);
    end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    pc             = '0;
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_taken      = 1'b0;
    upd_target     = '0;
    upd_uncond     = 1'b0;
    upd_mispredict = 1'b0;
    test_reset();
    test_alloc_taken();
    test_hysteresis();
    test_uncond();
    test_same_cycle();
    test_mispredict();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
